iq_rx_sample_buffer: RTL and testbench
======================================

IQ_RX_SAMPLE_BUFFER -- requirements
Module: iq_rx_sample_buffer

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16: output sample width per I/Q component.
REQ-002 The block SHALL have parameter IN_SIZE, default 16: input sample width per component; IN_SIZE <= DATA_SIZE.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 11: buffer depth = 2**DEPTH_LOG2 I/Q pairs.
REQ-004 The block SHALL have parameter OVF_MODE, default 0: 0 = drop newest on full, 1 = drop oldest on full.
REQ-005 The block SHALL have the ports i_clk (in, 1, sole clock) and i_reset (in, 1, synchronous, active-high reset).
REQ-006 The block SHALL have the ports i_en (in, 1, global enable) and i_valid (in, 1, input sample strobe).
REQ-007 The block SHALL have the ports in_data_i and in_data_q (in, IN_SIZE each, signed samples).
REQ-008 The block SHALL have the port i_shift (in, 3, arithmetic right-shift amount, 0..7).
REQ-009 The block SHALL have the port i_rd_req (in, 1, consumer read request; matches o_flag_wayt_data of ofdm_frame_res).
REQ-010 The block SHALL have the ports o_valid (out, 1) and o_data_i, o_data_q (out, DATA_SIZE each).
REQ-011 The block SHALL have the ports o_empty, o_full (out, 1 each) and o_level (out, DEPTH_LOG2+1, stored pairs).
REQ-012 The block SHALL have the ports o_overflow, o_underflow (out, 1 each, sticky), o_ovf_count (out, 16) and i_clear_flags (in, 1).

Function
REQ-013 The block SHALL sign-extend each input component to DATA_SIZE bits, then shift it right arithmetically by i_shift before storage (e.g. i_shift=3, 16'h8000 -> 16'hF000).
REQ-014 The block SHALL accept a write when i_en=1 and i_valid=1, subject to REQ-017/018.
REQ-015 The block SHALL accept a read when i_en=1, i_rd_req=1 and o_empty=0; o_data_i/q SHALL show the oldest pair with o_valid=1 exactly one cycle later (read latency 1), and the stored order SHALL be preserved.
REQ-016 The block SHALL hold o_data_i/q at its last value when no read is accepted, with o_valid=0 on those cycles.
REQ-017 The block SHALL, when full with OVF_MODE=0, discard the incoming write, set o_overflow and increment o_ovf_count.
REQ-018 The block SHALL, when full with OVF_MODE=1, advance the read pointer and store the new pair, set o_overflow and increment o_ovf_count; o_level SHALL stay at 2**DEPTH_LOG2.
REQ-019 The block SHALL treat a write and a read accepted in the same cycle while full as a normal write and read, with no overflow and o_level unchanged.
REQ-020 The block SHALL, on a simultaneous write and read request while empty, store the write and reject the read (no fall-through), setting o_underflow; o_valid SHALL stay 0.
REQ-021 The block SHALL set o_underflow on any i_rd_req=1 with i_en=1 while o_empty=1.
REQ-022 The block SHALL saturate o_ovf_count at 16'hFFFF.
REQ-023 The block SHALL let pointers wrap modulo 2**DEPTH_LOG2, and o_level SHALL equal writes minus reads, in the range 0..2**DEPTH_LOG2.
REQ-024 The block SHALL register o_empty, o_full and o_level, each valid in the cycle after the access that changes it.
REQ-025 The block SHALL clear o_overflow, o_underflow and o_ovf_count on i_clear_flags=1; an event in the same cycle SHALL win, leaving the flag set and o_ovf_count=1.
REQ-026 The block SHALL, with i_en=0, ignore i_valid and i_rd_req, and all state SHALL hold.

Reset
REQ-027 The block SHALL, on i_reset=1 at a rising i_clk, clear pointers and o_level to 0, set o_empty=1 and o_full=0, set o_valid=0, o_data_i/q=0, o_overflow=0, o_underflow=0 and o_ovf_count=0.
REQ-028 The block SHALL let reset mid-operation discard all stored data, with no read completing in the following cycle.

Verification
REQ-029 Write pairs (100,-100),(8,-8) with i_shift=3, then read -> o_valid on the cycle after each read, data (12,-13),(1,-1).
REQ-030 DEPTH_LOG2=4, OVF_MODE=0: write 20 pairs 0..19 with no reads -> o_full=1, o_ovf_count=4, reading out yields 0..15.
REQ-031 DEPTH_LOG2=4, OVF_MODE=1: write 20 pairs 0..19 -> o_level=16, o_ovf_count=4, reading out yields 4..19.
REQ-032 Full buffer, simultaneous write and read for 10 cycles -> o_overflow=0, o_level=16 throughout, data in order.
REQ-033 Empty buffer, i_valid=1 and i_rd_req=1 in the same cycle -> o_underflow=1, o_valid=0, o_level=1 on the next cycle.
REQ-034 Write 5 pairs, assert i_reset for one cycle, then i_rd_req=1 -> o_empty=1, o_valid stays 0, o_underflow=1.

Source files
------------

// File: rtl/iq_rx_sample_buffer.sv
// Purpose: I/Q sample FIFO with sign-extend and arithmetic pre-shift, overflow/underflow tracking.
// Latency: read data and o_valid one cycle after an accepted read; status registered one cycle after access.
// Backpressure: none upstream; when full, drops newest (OVF_MODE=0) or oldest (OVF_MODE=1).
module iq_rx_sample_buffer #(
    parameter int DATA_SIZE  = 16,
    parameter int IN_SIZE    = 16,
    parameter int DEPTH_LOG2 = 11,
    parameter int OVF_MODE   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [IN_SIZE-1:0]    in_data_i,
    input  logic [IN_SIZE-1:0]    in_data_q,
    input  logic [2:0]            i_shift,
    input  logic                  i_rd_req,
    output logic                  o_valid,
    output logic [DATA_SIZE-1:0]  o_data_i,
    output logic [DATA_SIZE-1:0]  o_data_q,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic [15:0]           o_ovf_count,
    input  logic                  i_clear_flags
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [DATA_SIZE-1:0] i;
        logic [DATA_SIZE-1:0] q;
    } iq_t;

    iq_t                   mem [DEPTH];
    iq_t                   wr_pair;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic signed [DATA_SIZE-1:0] ext_i, ext_q;
    logic                  wr_req, rd_req, rd_acc, wr_acc, drop_old, rd_adv;
    logic                  ovf_evt, udf_evt;
    logic [LVL_W-1:0]      level_nxt;

    always_comb begin
        ext_i     = DATA_SIZE'($signed(in_data_i));
        ext_q     = DATA_SIZE'($signed(in_data_q));
        wr_pair.i = ext_i >>> i_shift;
        wr_pair.q = ext_q >>> i_shift;

        wr_req   = i_en & i_valid;
        rd_req   = i_en & i_rd_req;
        rd_acc   = rd_req & ~o_empty;
        // A read in the same cycle frees the slot, so a full-buffer write only overflows without one.
        ovf_evt  = wr_req & o_full & ~rd_acc;
        udf_evt  = rd_req & o_empty;
        drop_old = (OVF_MODE == 1) & ovf_evt;
        wr_acc   = wr_req & (~ovf_evt | drop_old);
        rd_adv   = rd_acc | drop_old;

        level_nxt = o_level;
        if (wr_acc && !rd_adv)
            level_nxt = o_level + LVL_W'(1);
        else if (!wr_acc && rd_adv)
            level_nxt = o_level - LVL_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_reset)
            mem[wr_ptr] <= wr_pair;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_level     <= '0;
            o_empty     <= 1'b1;
            o_full      <= 1'b0;
            o_valid     <= 1'b0;
            o_data_i    <= '0;
            o_data_q    <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_ovf_count <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (rd_adv)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            o_level <= level_nxt;
            o_empty <= (level_nxt == '0);
            o_full  <= (level_nxt == LVL_W'(DEPTH));

            o_valid <= rd_acc;
            if (rd_acc) begin
                o_data_i <= mem[rd_ptr].i;
                o_data_q <= mem[rd_ptr].q;
            end

            // Same-cycle events win over a clear.
            if (i_clear_flags) begin
                o_overflow  <= ovf_evt;
                o_underflow <= udf_evt;
                o_ovf_count <= {15'd0, ovf_evt};
            end else begin
                o_overflow  <= o_overflow | ovf_evt;
                o_underflow <= o_underflow | udf_evt;
                if (ovf_evt && o_ovf_count != 16'hFFFF)
                    o_ovf_count <= o_ovf_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_iq_rx_sample_buffer.sv
// Directed bench: two 16-deep instances, drop-newest (a_*) and drop-oldest (b_*), share all inputs.
module tb_iq_rx_sample_buffer;
    logic        clk = 1'b0;
    logic        rst, en, vld, rd, clr;
    logic [15:0] di, dq;
    logic [2:0]  shift;

    logic        a_valid, a_empty, a_full, a_ovf, a_udf;
    logic [15:0] a_di, a_dq, a_cnt;
    logic [4:0]  a_level;
    logic        b_valid, b_empty, b_full, b_ovf, b_udf;
    logic [15:0] b_di, b_dq, b_cnt;
    logic [4:0]  b_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iq_rx_sample_buffer #(.DATA_SIZE(16), .IN_SIZE(16), .DEPTH_LOG2(4), .OVF_MODE(0)) u_a (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_valid(vld),
        .in_data_i(di), .in_data_q(dq), .i_shift(shift), .i_rd_req(rd),
        .o_valid(a_valid), .o_data_i(a_di), .o_data_q(a_dq),
        .o_empty(a_empty), .o_full(a_full), .o_level(a_level),
        .o_overflow(a_ovf), .o_underflow(a_udf), .o_ovf_count(a_cnt),
        .i_clear_flags(clr));

    iq_rx_sample_buffer #(.DATA_SIZE(16), .IN_SIZE(16), .DEPTH_LOG2(4), .OVF_MODE(1)) u_b (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_valid(vld),
        .in_data_i(di), .in_data_q(dq), .i_shift(shift), .i_rd_req(rd),
        .o_valid(b_valid), .o_data_i(b_di), .o_data_q(b_dq),
        .o_empty(b_empty), .o_full(b_full), .o_level(b_level),
        .o_overflow(b_ovf), .o_underflow(b_udf), .o_ovf_count(b_cnt),
        .i_clear_flags(clr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; vld = 1'b0; rd = 1'b0; clr = 1'b0;
        di = '0; dq = '0; shift = '0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({a_empty, a_full, a_valid, a_ovf, a_udf, a_level, a_di, a_dq, a_cnt} !== {5'b10000, 5'd0, 48'd0}) begin
            errors++;
            $display("FAIL reset_a: e=%b f=%b v=%b o=%b u=%b lvl=%0d i=%h q=%h cnt=%0d want e=1 rest 0",
                     a_empty, a_full, a_valid, a_ovf, a_udf, a_level, a_di, a_dq, a_cnt);
        end
        checks++;
        if ({b_empty, b_full, b_valid, b_ovf, b_udf, b_level, b_di, b_dq, b_cnt} !== {5'b10000, 5'd0, 48'd0}) begin
            errors++;
            $display("FAIL reset_b: e=%b f=%b v=%b o=%b u=%b lvl=%0d i=%h q=%h cnt=%0d want e=1 rest 0",
                     b_empty, b_full, b_valid, b_ovf, b_udf, b_level, b_di, b_dq, b_cnt);
        end
    endtask

    task automatic test_shift();
        logic [15:0] ei [3];
        logic [15:0] eq [3];
        ei[0] = 16'd12;   eq[0] = 16'hFFF3;
        ei[1] = 16'd1;    eq[1] = 16'hFFFF;
        ei[2] = 16'hF000; eq[2] = 16'h0FFF;
        en = 1'b1; shift = 3'd3; vld = 1'b1;
        di = 16'd100;  dq = 16'hFF9C; tick();
        di = 16'd8;    dq = 16'hFFF8; tick();
        di = 16'h8000; dq = 16'h7FFF; tick();
        vld = 1'b0;
        checks++;
        if (a_level !== 5'd3 || b_level !== 5'd3 || a_empty !== 1'b0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL shift_level: a=%0d b=%0d empty=%b valid=%b want 3 3 0 0", a_level, b_level, a_empty, a_valid);
        end
        rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({a_valid, a_di, a_dq} !== {1'b1, ei[k], eq[k]} || {b_valid, b_di, b_dq} !== {1'b1, ei[k], eq[k]}) begin
                errors++;
                $display("FAIL shift_rd%0d: a v=%b %h/%h b v=%b %h/%h want 1 %h/%h",
                         k, a_valid, a_di, a_dq, b_valid, b_di, b_dq, ei[k], eq[k]);
            end
        end
        rd = 1'b0;
        tick();
        checks++;
        if ({a_valid, a_di, a_dq, a_empty} !== {1'b0, 16'hF000, 16'h0FFF, 1'b1}) begin
            errors++;
            $display("FAIL hold_idle: v=%b %h/%h empty=%b want 0 f000/0fff 1", a_valid, a_di, a_dq, a_empty);
        end
    endtask

    task automatic test_overflow();
        shift = 3'd0; vld = 1'b1;
        for (int k = 0; k < 20; k++) begin
            di = k[15:0]; dq = 16'(-k); tick();
        end
        vld = 1'b0;
        checks++;
        if ({a_full, a_ovf, a_level, a_cnt} !== {2'b11, 5'd16, 16'd4}) begin
            errors++;
            $display("FAIL ovf_drop_newest: full=%b ovf=%b lvl=%0d cnt=%0d want 1 1 16 4", a_full, a_ovf, a_level, a_cnt);
        end
        checks++;
        if ({b_full, b_ovf, b_level, b_cnt} !== {2'b11, 5'd16, 16'd4}) begin
            errors++;
            $display("FAIL ovf_drop_oldest: full=%b ovf=%b lvl=%0d cnt=%0d want 1 1 16 4", b_full, b_ovf, b_level, b_cnt);
        end
        clr = 1'b1; vld = 1'b1; di = 16'd20; dq = 16'(-20);
        tick();
        clr = 1'b0; vld = 1'b0;
        checks++;
        if ({a_ovf, a_cnt, b_ovf, b_cnt, b_level} !== {1'b1, 16'd1, 1'b1, 16'd1, 5'd16}) begin
            errors++;
            $display("FAIL clear_vs_ovf: a o=%b c=%0d b o=%b c=%0d lvl=%0d want 1 1 1 1 16", a_ovf, a_cnt, b_ovf, b_cnt, b_level);
        end
        rd = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if ({a_valid, a_di, a_dq} !== {1'b1, k[15:0], 16'(-k)}) begin
                errors++;
                $display("FAIL ovf_a_rd%0d: v=%b %h/%h want 1 %h/%h", k, a_valid, a_di, a_dq, k[15:0], 16'(-k));
            end
            checks++;
            if ({b_valid, b_di, b_dq} !== {1'b1, 16'(k + 5), 16'(-(k + 5))}) begin
                errors++;
                $display("FAIL ovf_b_rd%0d: v=%b %h/%h want 1 %h/%h", k, b_valid, b_di, b_dq, 16'(k + 5), 16'(-(k + 5)));
            end
        end
        rd = 1'b0;
        tick();
        checks++;
        if ({a_empty, a_valid, b_empty, b_valid, a_level, b_level} !== {4'b1010, 10'd0}) begin
            errors++;
            $display("FAIL ovf_drained: a e=%b v=%b b e=%b v=%b want 1 0 1 0", a_empty, a_valid, b_empty, b_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if ({a_ovf, a_cnt, b_ovf, b_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL clear_flags: a o=%b c=%0d b o=%b c=%0d want 0", a_ovf, a_cnt, b_ovf, b_cnt);
        end
        vld = 1'b1;
        for (int k = 0; k < 16; k++) begin
            di = 16'(100 + k); dq = 16'(-(100 + k)); tick();
        end
        checks++;
        if ({a_full, a_level, a_ovf, b_full, b_level, b_ovf} !== {1'b1, 5'd16, 1'b0, 1'b1, 5'd16, 1'b0}) begin
            errors++;
            $display("FAIL fill16: a f=%b l=%0d o=%b b f=%b l=%0d o=%b", a_full, a_level, a_ovf, b_full, b_level, b_ovf);
        end
        rd = 1'b1;
        for (int k = 0; k < 10; k++) begin
            di = 16'(200 + k); dq = 16'(-(200 + k)); tick();
            e = 16'(100 + k);
            checks++;
            if ({a_ovf, a_level, a_valid, a_di, b_ovf, b_level, b_valid, b_di} !== {1'b0, 5'd16, 1'b1, e, 1'b0, 5'd16, 1'b1, e}) begin
                errors++;
                $display("FAIL full_rw%0d: a o=%b l=%0d v=%b i=%0d b o=%b l=%0d v=%b i=%0d want 0 16 1 %0d",
                         k, a_ovf, a_level, a_valid, a_di, b_ovf, b_level, b_valid, b_di, e);
            end
        end
        vld = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            e = (k < 6) ? 16'(110 + k) : 16'(200 + k - 6);
            checks++;
            if ({a_valid, a_di, a_dq, b_di} !== {1'b1, e, 16'(-e), e}) begin
                errors++;
                $display("FAIL drain%0d: v=%b a=%0d/%h b=%0d want %0d", k, a_valid, a_di, a_dq, b_di, e);
            end
        end
        rd = 1'b0;
        tick();
        checks++;
        if ({a_empty, b_empty, a_ovf, b_ovf} !== 4'b1100) begin
            errors++;
            $display("FAIL rw_end: a e=%b b e=%b a o=%b b o=%b want 1 1 0 0", a_empty, b_empty, a_ovf, b_ovf);
        end
    endtask

    task automatic test_underflow();
        vld = 1'b1; rd = 1'b1; di = 16'd7; dq = 16'hFFF9;
        tick();
        vld = 1'b0; rd = 1'b0;
        checks++;
        if ({a_udf, a_valid, a_level, b_udf, b_valid, b_level} !== {2'b10, 5'd1, 2'b10, 5'd1}) begin
            errors++;
            $display("FAIL empty_wr_rd: a u=%b v=%b l=%0d b u=%b v=%b l=%0d want 1 0 1", a_udf, a_valid, a_level, b_udf, b_valid, b_level);
        end
        rd = 1'b1; tick(); rd = 1'b0;
        checks++;
        if ({a_valid, a_di, a_dq, a_empty} !== {1'b1, 16'd7, 16'hFFF9, 1'b1}) begin
            errors++;
            $display("FAIL no_fallthrough_rd: v=%b %h/%h e=%b want 1 0007/fff9 1", a_valid, a_di, a_dq, a_empty);
        end
        clr = 1'b1; rd = 1'b1; tick(); clr = 1'b0; rd = 1'b0;
        checks++;
        if ({a_udf, b_udf, a_valid} !== 3'b110) begin
            errors++;
            $display("FAIL clear_vs_udf: a u=%b b u=%b v=%b want 1 1 0", a_udf, b_udf, a_valid);
        end
    endtask

    task automatic test_enable_reset();
        clr = 1'b1; tick(); clr = 1'b0;
        vld = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            di = k[15:0]; dq = 16'(-k); tick();
        end
        en = 1'b0; rd = 1'b1;
        tick(); tick();
        checks++;
        if ({a_level, a_valid, a_udf, b_level, b_valid} !== {5'd5, 2'b00, 5'd5, 1'b0}) begin
            errors++;
            $display("FAIL enable_hold: a l=%0d v=%b u=%b b l=%0d v=%b want 5 0 0 5 0", a_level, a_valid, a_udf, b_level, b_valid);
        end
        en = 1'b1; vld = 1'b0; rd = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({a_empty, a_level, a_valid, b_empty, b_level} !== {1'b1, 5'd0, 1'b0, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL midreset: a e=%b l=%0d v=%b b e=%b l=%0d want 1 0 0", a_empty, a_level, a_valid, b_empty, b_level);
        end
        rd = 1'b1; tick(); rd = 1'b0;
        checks++;
        if ({a_empty, a_valid, a_udf, b_empty, b_valid, b_udf} !== 6'b101101) begin
            errors++;
            $display("FAIL post_reset_rd: a e=%b v=%b u=%b b e=%b v=%b u=%b want 1 0 1", a_empty, a_valid, a_udf, b_empty, b_valid, b_udf);
        end
        tick();
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_valid: a=%b b=%b want 0", a_valid, b_valid);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_enable_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
